pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Owns the architectural PC and EPC registers and sequences next-PC selection for fetch.
//   Arbitrates each cycle between sequential fetch, branch/jump redirect, SIIC exception entry,
//   RTI return and halt, which are the same choices the next-PC mux datapath makes.
//   Tracks handler mode with a 3-state FSM; raises flush toward decode on every non-sequential PC change.
//   Sits between the fetch stage (consumes pc) and the decode/control unit (produces requests).
// PARAMETERS
//   RESET_PC    16'h0000  PC value loaded on reset
//   HANDLER_PC  16'h0002  exception handler entry address (SIIC vector)
// PORTS
//   clk         in   1   system clock, all state updates on rising edge
//   rst         in   1   reset, asynchronous, active-low
//   stall       in   1   1 = hold PC/EPC/state; requests ignored this cycle
//   redirect    in   1   taken branch or jump this cycle
//   target      in   16  redirect destination (from adder datapath), must be even
//   siic        in   1   illegal-instruction exception request
//   rti         in   1   return-from-interrupt request
//   halt_req    in   1   HALT instruction decoded
//   pc          out  16  current fetch PC (registered)
//   pc_plus2    out  16  pc + 2, mod 2^16 (combinational)
//   epc         out  16  saved exception PC (registered)
//   flush       out  1   combinational; 1 when a non-sequential PC change is accepted this cycle
//   in_handler  out  1   1 while FSM in HANDLER
//   halted      out  1   1 while FSM in HALT
//   err         out  1   registered sticky error flag
// BEHAVIOUR
//   Reset (rst=0, async): pc=RESET_PC, epc=16'h0000, state=RUN, err=0; flush=0, in_handler=0, halted=0.
//   States: RUN, HANDLER, HALT. Encoding is free; in_handler/halted decode directly from state.
//   Request is "accepted" only when stall=0 and state!=HALT; accepted requests take effect at next edge.
//   Priority among simultaneous accepted requests: halt_req > siic > rti > redirect > sequential.
//   RUN:
//     halt_req          -> HALT, pc held, flush=0.
//     siic              -> HANDLER, epc<=pc_plus2, pc<=HANDLER_PC, flush=1.
//     rti               -> illegal: err<=1, HALT, flush=1.
//     redirect          -> target[0]=1: err<=1, HALT, flush=1; else pc<=target, flush=1.
//     none              -> pc<=pc_plus2, flush=0.
//   HANDLER:
//     halt_req          -> HALT.
//     siic (nested)     -> err<=1, HALT, flush=1; epc unchanged.
//     rti               -> RUN, pc<=epc, flush=1.
//     redirect/none     -> same PC rules as RUN (including misaligned check), stay HANDLER.
//   HALT: terminal until reset; pc, epc, err frozen; all inputs ignored; flush=0.
//   stall=1: pc, epc, state, err hold; flush=0; pending requests must be held by requester.
//   Wrap-around: pc=16'hFFFE sequential -> 16'h0000; no error. epc may wrap identically.
//   err is sticky; only reset clears it. Every err assertion coincides with entry to HALT.
//   Latency: one cycle from accepted request to new pc value; zero bubbles inserted internally.
//   Reset asserted mid-operation overrides any in-flight request immediately (async).
// TESTING
//   1. Reset, 4 unstalled cycles no requests -> pc 0000,0002,0004,0006,0008; flush=0 throughout.
//   2. pc=0x0010, redirect=1 target=0x0100 -> flush=1 that cycle; next pc=0x0100, state RUN.
//   3. pc=0x0020, siic=1 with redirect=1 -> epc=0x0022, pc=0x0002, in_handler=1; then rti ->
//      pc=0x0022, in_handler=0, flush=1 on both accepting cycles.
//   4. In HANDLER, siic=1 -> err=1, halted=1; further inputs leave pc/epc unchanged 10 cycles.
//   5. pc=0xFFFE sequential -> pc=0x0000, err=0; redirect target=0x0101 -> err=1, halted=1.
//   6. stall=1 with siic=1 for 3 cycles -> pc/epc/state unchanged, flush=0; drop stall -> exception
//      taken next edge; async rst=0 mid-cycle -> pc=0x0000 without waiting for clk.

Source files
------------

// File: rtl/pc_sequencer.sv
// PC/EPC owner and next-PC sequencer for fetch.
// Each cycle it picks one of: sequential fetch, redirect, exception entry,
// return from the handler, or halt. It also tracks handler mode and signals a flush.
//
// state   | meaning
// --------+--------------------------------------------------------------
// RUN     | normal execution; siic enters HANDLER, rti is illegal
// HANDLER | running the exception handler; rti returns, nested siic errs
// HALT    | terminal until reset; pc/epc/err frozen, inputs ignored
module pc_sequencer #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] HANDLER_PC = 16'h0002
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] target,
  input  logic        siic,
  input  logic        rti,
  input  logic        halt_req,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic [15:0] epc,
  output logic        flush,
  output logic        in_handler,
  output logic        halted,
  output logic        err
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_HANDLER = 2'd1,
    S_HALT    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] epc_q, epc_d;
  logic        err_q, err_d;
  logic        accept;

  assign accept     = !stall && (state_q != S_HALT);
  assign pc         = pc_q;
  assign pc_plus2   = pc_q + 16'd2;
  assign epc        = epc_q;
  assign err        = err_q;
  assign in_handler = (state_q == S_HANDLER);
  assign halted     = (state_q == S_HALT);

  // State, PC, EPC and sticky error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      epc_q   <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      err_q   <= err_d;
    end
  end

  // Request arbitration: halt_req > siic > rti > redirect > sequential.
  // Every error path also enters HALT and holds pc where it is.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    err_d   = err_q;
    flush   = 1'b0;
    if (accept) begin
      if (halt_req) begin
        state_d = S_HALT;
      end else if (siic) begin
        flush = 1'b1;
        if (state_q == S_RUN) begin
          state_d = S_HANDLER;
          epc_d   = pc_plus2;
          pc_d    = HANDLER_PC;
        end else begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end
      end else if (rti) begin
        flush = 1'b1;
        if (state_q == S_HANDLER) begin
          state_d = S_RUN;
          pc_d    = epc_q;
        end else begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end
      end else if (redirect) begin
        flush = 1'b1;
        if (target[0]) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          pc_d = target;
        end
      end else begin
        pc_d = pc_plus2;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a mode/PC reference model and literal pins.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] target = 16'h0000;
  logic        siic = 1'b0;
  logic        rti = 1'b0;
  logic        halt_req = 1'b0;
  logic [15:0] pc, pc_plus2, epc;
  logic        flush, in_handler, halted, err;

  int total = 0;
  int bad   = 0;

  localparam int M_RUN = 0, M_HND = 1, M_HALT = 2;
  logic [15:0] m_pc, m_epc;
  int          m_mode;
  logic        m_err;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .target(target),
    .siic(siic), .rti(rti), .halt_req(halt_req), .pc(pc), .pc_plus2(pc_plus2),
    .epc(epc), .flush(flush), .in_handler(in_handler), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_flush();
    if (stall || m_mode == M_HALT || halt_req) return 1'b0;
    return siic || rti || redirect;
  endfunction

  task automatic model_reset();
    m_pc = 16'h0000; m_epc = 16'h0000; m_mode = M_RUN; m_err = 1'b0;
  endtask

  // Reference behaviour of one clock edge, written from the request rules.
  task automatic model_step();
    if (stall || m_mode == M_HALT) return;
    if (halt_req) m_mode = M_HALT;
    else if (siic && m_mode == M_RUN) begin
      m_epc = m_pc + 16'd2; m_pc = 16'h0002; m_mode = M_HND;
    end else if (siic) begin
      m_err = 1'b1; m_mode = M_HALT;
    end else if (rti && m_mode == M_HND) begin
      m_pc = m_epc; m_mode = M_RUN;
    end else if (rti) begin
      m_err = 1'b1; m_mode = M_HALT;
    end else if (redirect && target[0]) begin
      m_err = 1'b1; m_mode = M_HALT;
    end else if (redirect) m_pc = target;
    else m_pc = m_pc + 16'd2;
  endtask

  task automatic compare_all();
    check("pc", pc, m_pc);
    check("pc_plus2", pc_plus2, m_pc + 16'd2);
    check("epc", epc, m_epc);
    check("flush", {15'd0, flush}, {15'd0, m_flush()});
    check("in_handler", {15'd0, in_handler}, {15'd0, m_mode == M_HND});
    check("halted", {15'd0, halted}, {15'd0, m_mode == M_HALT});
    check("err", {15'd0, err}, {15'd0, m_err});
  endtask

  // Called just after a rising edge with inputs set: compare mid-cycle, then advance one edge.
  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_req();
    stall = 0; redirect = 0; target = 16'h0000; siic = 0; rti = 0; halt_req = 0;
  endtask

  // Asserts reset between edges and checks that it acts without a clock.
  task automatic reset_mid();
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("rst_pc", pc, 16'h0000);
    check("rst_epc", epc, 16'h0000);
    check("rst_state", {13'd0, in_handler, halted, err}, 16'h0000);
    clear_req();
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    // 1: reset then sequential fetch
    reset_mid();
    check("seq_pc0", pc, 16'h0000);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("seq_pc", pc, 16'(2 * i));
    end

    // 2: redirect from 0x0010
    redirect = 1; target = 16'h0100;
    #1 check("redir_flush", {15'd0, flush}, 16'h0001);
    tick();
    check("redir_pc", pc, 16'h0100);
    check("redir_run", {15'd0, in_handler}, 16'h0000);

    // 3: siic beats redirect, then rti returns
    target = 16'h0020;
    tick();
    siic = 1; redirect = 1; target = 16'h0040;
    #1 check("siic_flush", {15'd0, flush}, 16'h0001);
    tick();
    check("siic_epc", epc, 16'h0022);
    check("siic_pc", pc, 16'h0002);
    check("siic_hnd", {15'd0, in_handler}, 16'h0001);
    clear_req();
    tick();
    check("hnd_seq", pc, 16'h0004);
    stall = 1; rti = 1;
    tick();
    check("hnd_stall", pc, 16'h0004);
    stall = 0;
    #1 check("rti_flush", {15'd0, flush}, 16'h0001);
    tick();
    check("rti_pc", pc, 16'h0022);
    check("rti_run", {15'd0, in_handler}, 16'h0000);
    clear_req();

    // 5: wrap-around then misaligned redirect
    redirect = 1; target = 16'hFFFE;
    tick();
    clear_req();
    tick();
    check("wrap_pc", pc, 16'h0000);
    check("wrap_err", {15'd0, err}, 16'h0000);
    redirect = 1; target = 16'h0101;
    tick();
    check("mis_err", {15'd0, err}, 16'h0001);
    check("mis_halt", {15'd0, halted}, 16'h0001);
    clear_req();
    tick();

    // 4: nested siic, then HALT ignores everything
    reset_mid();
    siic = 1;
    tick();
    check("nest_epc0", epc, 16'h0002);
    tick();
    check("nest_err", {15'd0, err}, 16'h0001);
    check("nest_halt", {15'd0, halted}, 16'h0001);
    for (int i = 0; i < 10; i++) begin
      siic = i[0]; rti = i[1]; redirect = 1; target = 16'(16 * i); halt_req = i[2];
      tick();
    end
    check("halt_pc", pc, 16'h0002);
    check("halt_epc", epc, 16'h0002);
    clear_req();

    // halt_req has priority over siic, no flush, no error
    reset_mid();
    halt_req = 1; siic = 1;
    #1 check("halt_flush", {15'd0, flush}, 16'h0000);
    tick();
    check("halt_req_st", {13'd0, in_handler, halted, err}, 16'h0002);
    check("halt_req_pc", pc, 16'h0000);

    // rti outside the handler is illegal
    reset_mid();
    tick();
    rti = 1;
    tick();
    check("rti_ill", {13'd0, in_handler, halted, err}, 16'h0003);
    check("rti_ill_pc", pc, 16'h0002);

    // 6: stall holds pending siic, then exception, then async reset mid-cycle
    reset_mid();
    tick();
    tick();
    stall = 1; siic = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", pc, 16'h0004);
    end
    stall = 0;
    tick();
    check("unstall_pc", pc, 16'h0002);
    check("unstall_epc", epc, 16'h0006);
    check("unstall_hnd", {15'd0, in_handler}, 16'h0001);
    clear_req();
    tick();
    reset_mid();
    tick();
    check("post_rst_pc", pc, 16'h0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
